// File: rtl/pa_noc.sv
// Shared APB-over-NoC packet definitions used by the router, requester NI and completer NI.
package pa_noc;

  localparam int unsigned APB_PACKET_WIDTH = 60;
  localparam int unsigned COORD_WIDTH      = 2;

  // Field bit positions inside a packet
  localparam int unsigned PKT_DST_COL_LSB = 0;
  localparam int unsigned PKT_DST_ROW_LSB = 2;
  localparam int unsigned PKT_SRC_COL_LSB = 4;
  localparam int unsigned PKT_SRC_ROW_LSB = 6;
  localparam int unsigned PKT_VALID_BIT   = 8;
  localparam int unsigned PKT_TYPE_BIT    = 9;
  localparam int unsigned PKT_PWRITE_BIT  = 10;
  localparam int unsigned PKT_PSLVERR_BIT = 11;
  localparam int unsigned PKT_ADDR_LSB    = 12;
  localparam int unsigned PKT_DATA_LSB    = 28;

  typedef enum logic {
    REQUEST  = 1'b0,
    RESPONSE = 1'b1
  } pkt_type_e;

  typedef struct packed {
    logic [31:0]            data;
    logic [15:0]            addr;
    logic                   pslverr;
    logic                   pwrite;
    pkt_type_e              ptype;
    logic                   valid;
    logic [COORD_WIDTH-1:0] src_row;
    logic [COORD_WIDTH-1:0] src_col;
    logic [COORD_WIDTH-1:0] dst_row;
    logic [COORD_WIDTH-1:0] dst_col;
  } apb_packet_t;

endpackage

// File: rtl/ni_apb_requester.sv
// Requester NI: turns one APB transfer into a request packet and completes it on the matching
// response. Optional response timeout enabled by defining NOC_NI_TIMEOUT_EN.
module ni_apb_requester
  import pa_noc::*;
#(
  parameter int unsigned GRID_WIDTH     = 4,
  parameter int unsigned NODE_ROW       = 0,
  parameter int unsigned NODE_COL       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                 i_clk,
  input  logic                                 i_srst_n,
  input  logic                                 i_psel,
  input  logic                                 i_penable,
  input  logic                                 i_pwrite,
  input  logic [15:0]                          i_paddr,
  input  logic [31:0]                          i_pwdata,
  output logic                                 o_pready,
  output logic [31:0]                          o_prdata,
  output logic                                 o_pslverr,
  output logic [pa_noc::APB_PACKET_WIDTH-1:0]  o_apbPacket,
  input  logic [pa_noc::APB_PACKET_WIDTH-1:0]  i_apbPacket
);

  if (GRID_WIDTH != 4 || NODE_ROW >= GRID_WIDTH || NODE_COL >= GRID_WIDTH ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 ||
      $bits(apb_packet_t) != APB_PACKET_WIDTH) begin : g_param_check
    $error("ni_apb_requester: illegal parameter combination");
  end

  localparam logic [1:0] OwnRow = 2'(NODE_ROW);
  localparam logic [1:0] OwnCol = 2'(NODE_COL);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

  state_e      state_q, state_d;
  apb_packet_t pkt_q, pkt_d;
  logic [3:0]  tgt_q, tgt_d;
  logic        pready_q, pready_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pslverr_q, pslverr_d;

  apb_packet_t rsp;
  logic        rsp_match;
  logic        expired;
  logic        unused_rsp;

  assign rsp = apb_packet_t'(i_apbPacket);

  // Only responses addressed to us from the node we sent the request to complete the transfer
  assign rsp_match = rsp.valid && (rsp.ptype == RESPONSE) &&
                     (rsp.dst_row == OwnRow) && (rsp.dst_col == OwnCol) &&
                     ({rsp.src_row, rsp.src_col} == tgt_q);

  assign unused_rsp = ^{rsp.addr, rsp.pwrite};

`ifdef NOC_NI_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign expired = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pkt_d     = '0;
    tgt_d     = tgt_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
`ifdef NOC_NI_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_psel && !i_penable) begin
          tgt_d         = i_paddr[15:12];
          pkt_d.valid   = 1'b1;
          pkt_d.ptype   = REQUEST;
          pkt_d.pwrite  = i_pwrite;
          pkt_d.pslverr = 1'b0;
          pkt_d.addr    = i_paddr;
          pkt_d.data    = i_pwrite ? i_pwdata : 32'h0;
          pkt_d.dst_row = i_paddr[15:14];
          pkt_d.dst_col = i_paddr[13:12];
          pkt_d.src_row = OwnRow;
          pkt_d.src_col = OwnCol;
          state_d       = StSend;
        end
      end
      StSend: begin
        state_d = StWait;
`ifdef NOC_NI_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
`ifdef NOC_NI_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
`endif
        if (rsp_match) begin
          state_d   = StDone;
          pready_d  = 1'b1;
          prdata_d  = rsp.data;
          pslverr_d = rsp.pslverr;
        end else if (expired) begin
          state_d   = StDone;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      state_q   <= StIdle;
      pkt_q     <= '0;
      tgt_q     <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      tgt_q     <= tgt_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

`ifdef NOC_NI_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign o_apbPacket = pkt_q;
  assign o_pready    = pready_q;
  assign o_prdata    = prdata_q;
  assign o_pslverr   = pslverr_q;

endmodule

// File: doc/ni_apb_requester.md
# ni_apb_requester

Requester-side network interface: accepts one APB transfer at a time from the local APB master, encodes it as a single-cycle request packet into the local router's NI input, then waits for the matching response packet from the router's NI output and completes the APB transfer. One instance per grid node, directly upstream and downstream of that node's router.

## Interface
- `GRID_WIDTH`, default 4: grid dimension; coordinate width is fixed at 2 bits by the packet format, so only 4 is legal.
- `NODE_ROW`, default 0: this node's row.
- `NODE_COL`, default 0: this node's column.
- `TIMEOUT_CYCLES`, default 64: response timeout in cycles, range 2..65535. Used only with `NOC_NI_TIMEOUT_EN`.
- `i_clk` in 1: sole clock, rising edge.
- `i_srst_n` in 1: reset, synchronous, active-low.
- `i_psel` in 1: APB select.
- `i_penable` in 1: APB enable.
- `i_pwrite` in 1: APB write.
- `i_paddr` in 16: APB address; `[15:14]` is the destination row, `[13:12]` is the destination column.
- `i_pwdata` in 32: APB write data.
- `o_pready` out 1: APB ready.
- `o_prdata` out 32: APB read data.
- `o_pslverr` out 1: APB error.
- `o_apbPacket` out `pa_noc::APB_PACKET_WIDTH`: request packet to the router NI input.
- `i_apbPacket` in `pa_noc::APB_PACKET_WIDTH`: packet from the router NI output.

## Operation
- Packet format (`APB_PACKET_WIDTH` = 60):
  - `[1:0]` destination column, `[3:2]` destination row.
  - `[5:4]` source column, `[7:6]` source row.
  - `[8]` valid, `[9]` type (0 = request, 1 = response), `[10]` pwrite, `[11]` pslverr.
  - `[27:12]` addr, `[59:28]` data.
- The all-zero packet means idle. A valid packet is never all-zero because bit 8 is set.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE:
  - On `i_psel & !i_penable` (APB setup), capture `pwrite`, `paddr`, `pwdata`.
  - Destination = `{paddr[15:14], paddr[13:12]}`; source = `{NODE_ROW, NODE_COL}`.
  - Go to SEND.
- SEND:
  - `o_apbPacket` carries the request for exactly this one cycle: valid = 1, type = 0, data = `pwdata` for writes and 0 for reads, pslverr = 0.
  - Go to WAIT.
- WAIT: a response is accepted when `i_apbPacket` has all of:
  - valid = 1 and type = 1;
  - destination = own coordinates;
  - source = captured destination.
  - On acceptance, register data to `o_prdata` and bit 11 to `o_pslverr`, then go to DONE.
  - Non-matching packets, including request packets (type 0) meant for the completer NI, are ignored.
- DONE:
  - `o_pready` = 1 for exactly one cycle, with `o_prdata` and `o_pslverr` valid.
  - Go to IDLE.
  - `o_prdata` and `o_pslverr` return to 0 in IDLE.
- Self-addressed transfers (destination = own node) are legal; the router loops them back to the local completer.
- `i_penable`, `i_psel` and address changes after capture are ignored until IDLE is re-entered. The transfer completes regardless.
- A response arriving in IDLE, SEND or DONE is dropped.
- Reset mid-operation: return to IDLE and drop any pending transfer. A late response is then dropped per the rule above.

## Timing
- Reset values: `o_apbPacket` = 0, `o_pready` = 0, `o_prdata` = 0, `o_pslverr` = 0, state = IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- Setup sampled at edge E → `o_apbPacket` valid in cycle E+1 only.
- Response present in cycle R → `o_pready` high in cycle R+1.
- Minimum transfer, setup to `pready` cycle: 3 cycles + network round trip. Each router hop adds 1 cycle.
- Back-to-back: a new setup is accepted in the cycle after `pready` (IDLE).

## Configuration
- `NOC_NI_TIMEOUT_EN` defined:
  - A 16-bit counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES-1` without a matching response, go to DONE with `o_pslverr` = 1 and `o_prdata` = 0.
  - If a match occurs in the same cycle as expiry, the response wins.
- Not defined: no counter; WAIT persists until a match or reset. `TIMEOUT_CYCLES` is unused.

## Structure
- `pa_noc` holds:
  - `APB_PACKET_WIDTH`;
  - field bit-position constants;
  - the packet type enum (REQUEST, RESPONSE);
  - a packed struct for the packet, shared with the router and the completer NI.
- FSM state enum is local to the module.
- No sub-module; the timeout counter is inline under the macro.

## Test plan
- Write to node (2,1) from (0,0): `paddr` 0x9010, `pwdata` 0xDEADBEEF.
  - Expect one-cycle request packet: dest 2/1, src 0/0, type 0, data 0xDEADBEEF.
  - Inject matching response (pslverr 0) → `pready` one cycle later, `pslverr` 0.
- Read with injected response data 0x12345678, pslverr 1 → `prdata` = 0x12345678 and `pslverr` = 1 for exactly one `pready` cycle, then both 0.
- In WAIT, inject a response from the wrong source, then a type-0 packet, then the correct response → only the third completes the transfer.
- Reset asserted in WAIT, then a response injected → no `pready`; all outputs 0.
- Macro on, `TIMEOUT_CYCLES` = 8, no response → `pready` with `pslverr` = 1, `prdata` = 0 exactly 8 WAIT cycles after entry. A response arriving later is ignored.
- Back-to-back: two writes with setup in the cycle after the first `pready` → two request packets, two completions, no lost transfer.
